// File: rtl/gate_sched_pkg.sv
// ---------------------------------------------------------------------------
// gate_sched_pkg
// Shared definitions for the gate scheduler slice: FSM state encoding,
// grant-type constants, default barrier hold time and the tie-break helper.
// Imported by gate_hold_timer and gate_scheduler.
// ---------------------------------------------------------------------------
package gate_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      GRANT = 2'b01,
      HOLD  = 2'b10
   } state_t;

   typedef enum logic {
      ENTRY = 1'b0,
      EXIT  = 1'b1
   } grant_t;

   localparam int DEFAULT_OPEN_CYCLES = 8;
   localparam int DEFAULT_CNT_W       = 4;

   // Chooses which requester is served. Only meaningful when at least one
   // of the two requests is valid. On a tie, round-robin grants the type
   // opposite to the previous grant; fixed priority lets the exit win
   // because it frees capacity.
   function automatic grant_t pick_grant(input logic   entry_valid,
                                         input logic   exit_valid,
                                         input grant_t last_grant,
                                         input logic   rr_en);
      grant_t winner;
      if (entry_valid && exit_valid) begin
         if (rr_en) begin
            winner = (last_grant == EXIT) ? ENTRY : EXIT;
         end else begin
            winner = EXIT;
         end
      end else if (exit_valid) begin
         winner = EXIT;
      end else begin
         winner = ENTRY;
      end
      return winner;
   endfunction

endpackage : gate_sched_pkg

// File: rtl/gate_hold_timer.sv
// ---------------------------------------------------------------------------
// gate_hold_timer
// Loadable down-counter that times how long the barrier stays open.
//
// Ports:
//   clk        in            system clock, rising edge
//   reset      in            synchronous, active-low reset (count -> 0)
//   load       in            load load_value on the next edge (wins over en)
//   load_value in  [CNT_W]   value to load
//   en         in            decrement by one per edge while nonzero
//   done       out           count is on its last cycle (count <= 1)
// ---------------------------------------------------------------------------
module gate_hold_timer
   import gate_sched_pkg::*;
#(
   parameter int CNT_W = DEFAULT_CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_value,
   input  logic             en,
   output logic             done
);

   logic [CNT_W-1:0] count_q;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; blocking here would create order-dependent simulation.
   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_value;
      end else if (en && (count_q != '0)) begin
         count_q <= count_q - CNT_W'(1);
      end
   end

   // A loaded value of N gives exactly N enabled cycles before done is seen
   // in the last one; a zero count also reads as done so the FSM can never
   // stall in HOLD.
   assign done = (count_q <= CNT_W'(1));

endmodule : gate_hold_timer

// File: rtl/gate_scheduler.sv
// ---------------------------------------------------------------------------
// gate_scheduler
// Sequencer/arbiter in front of the parking occupancy FSM. Arbitrates the
// entry and exit gate requests, denies requests the occupancy FSM cannot
// legally serve, issues one entry/exit pulse per granted car and then keeps
// the barrier open for OPEN_CYCLES cycles before looking at requests again.
//
// Configuration macro:
//   GATE_SCHED_RR_EN  defined   -> round-robin on a tie (opposite of last grant)
//                     undefined -> fixed priority, exit wins a tie
//
// Parameters:
//   OPEN_CYCLES  barrier hold cycles after a grant, 1 .. 2**CNT_W-1
//   CNT_W        hold counter width
//
// Ports:
//   clk            in       system clock, rising edge
//   reset          in       synchronous, active-low reset
//   entry_req      in       entry sensor request (level)
//   exit_req       in       exit sensor request (level)
//   exit_slot_req  in  [2]  slot the exiting car leaves
//   is_full        in       occupancy FSM full flag
//   spots          in  [4]  occupancy map, 1 = occupied
//   entry_signal   out      one-cycle entry pulse to the occupancy FSM
//   exit_signal    out      one-cycle exit pulse to the occupancy FSM
//   exit_slot      out [2]  slot index, valid with exit_signal
//   entry_ack      out      one-cycle grant acknowledge, entry side
//   exit_ack       out      one-cycle grant acknowledge, exit side
//   entry_deny     out      one-cycle reject, entry side
//   exit_deny      out      one-cycle reject, exit side
//   gate_open      out      barrier drive
//   busy           out      scheduler is not IDLE
// All outputs are registered.
// ---------------------------------------------------------------------------
module gate_scheduler
   import gate_sched_pkg::*;
#(
   parameter int OPEN_CYCLES = DEFAULT_OPEN_CYCLES,
   parameter int CNT_W       = DEFAULT_CNT_W
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       entry_req,
   input  logic       exit_req,
   input  logic [1:0] exit_slot_req,
   input  logic       is_full,
   input  logic [3:0] spots,
   output logic       entry_signal,
   output logic       exit_signal,
   output logic [1:0] exit_slot,
   output logic       entry_ack,
   output logic       exit_ack,
   output logic       entry_deny,
   output logic       exit_deny,
   output logic       gate_open,
   output logic       busy
);

`ifdef GATE_SCHED_RR_EN
   localparam logic RR_EN = 1'b1;
`else
   localparam logic RR_EN = 1'b0;
`endif

   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(OPEN_CYCLES);

   state_t     state_q, state_d;
   grant_t     last_grant_q, last_grant_d;
   grant_t     winner;

   logic       entry_valid, exit_valid;
   logic       entry_signal_d, exit_signal_d;
   logic       entry_ack_d, exit_ack_d;
   logic       entry_deny_d, exit_deny_d;
   logic [1:0] exit_slot_d;
   logic       timer_load, timer_en, timer_done;

   // Barrier hold timer: loaded while in GRANT so its first HOLD cycle
   // already holds OPEN_CYCLES, then counted down once per HOLD cycle.
   gate_hold_timer #(
      .CNT_W (CNT_W)
   ) u_hold_timer (
      .clk        (clk),
      .reset      (reset),
      .load       (timer_load),
      .load_value (HOLD_LOAD),
      .en         (timer_en),
      .done       (timer_done)
   );

   // Legality of each request against the occupancy FSM's current view.
   assign entry_valid = entry_req & ~is_full;
   assign exit_valid  = exit_req  & spots[exit_slot_req];
   assign winner      = pick_grant(entry_valid, exit_valid, last_grant_q, RR_EN);

   // Next-state and next-output logic.
   // NOTE: every signal written here gets a default first; a path that leaves
   // one unassigned would infer a latch.
   always_comb begin
      state_d        = state_q;
      last_grant_d   = last_grant_q;
      exit_slot_d    = exit_slot;
      entry_signal_d = 1'b0;
      exit_signal_d  = 1'b0;
      entry_ack_d    = 1'b0;
      exit_ack_d     = 1'b0;
      entry_deny_d   = 1'b0;
      exit_deny_d    = 1'b0;
      timer_load     = 1'b0;
      timer_en       = 1'b0;

      case (state_q)
         IDLE: begin
            // Denies are independent of the grant decision, so a rejected
            // requester never blocks the other one in the same cycle.
            entry_deny_d = entry_req & is_full;
            exit_deny_d  = exit_req & ~spots[exit_slot_req];

            if (entry_valid || exit_valid) begin
               state_d      = GRANT;
               last_grant_d = winner;
               if (winner == EXIT) begin
                  exit_signal_d = 1'b1;
                  exit_ack_d    = 1'b1;
                  exit_slot_d   = exit_slot_req;
               end else begin
                  entry_signal_d = 1'b1;
                  entry_ack_d    = 1'b1;
               end
            end
         end

         GRANT: begin
            state_d    = HOLD;
            timer_load = 1'b1;
         end

         HOLD: begin
            // Requests arriving here are ignored until the return to IDLE.
            timer_en = 1'b1;
            if (timer_done) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Registered state and outputs. gate_open and busy are derived from the
   // next state so they rise with the grant pulse and fall on the edge that
   // re-enters IDLE.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         last_grant_q <= EXIT;
         entry_signal <= 1'b0;
         exit_signal  <= 1'b0;
         exit_slot    <= 2'b00;
         entry_ack    <= 1'b0;
         exit_ack     <= 1'b0;
         entry_deny   <= 1'b0;
         exit_deny    <= 1'b0;
         gate_open    <= 1'b0;
         busy         <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         entry_signal <= entry_signal_d;
         exit_signal  <= exit_signal_d;
         exit_slot    <= exit_slot_d;
         entry_ack    <= entry_ack_d;
         exit_ack     <= exit_ack_d;
         entry_deny   <= entry_deny_d;
         exit_deny    <= exit_deny_d;
         gate_open    <= (state_d != IDLE);
         busy         <= (state_d != IDLE);
      end
   end

endmodule : gate_scheduler
